// File: rtl/shot_pkg.sv
// Shared types and default constants for the shot controller and the logic
// that consumes its events (score, hit animation).
package shot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EVAL     = 2'd1,
      ST_REPORT   = 2'd2,
      ST_COOLDOWN = 2'd3
   } state_t;

   localparam int SCREEN_W            = 640;
   localparam int SCREEN_H            = 480;

   localparam int DEF_AMMO_MAX        = 3;
   localparam int DEF_DUCK_W          = 32;
   localparam int DEF_DUCK_H          = 32;
   localparam int DEF_FLASH_FRAMES    = 2;
   localparam int DEF_COOLDOWN_FRAMES = 15;

endpackage

// File: rtl/shot_hit_test.sv
// Combinational point-in-rectangle test against a DUCK_W x DUCK_H box whose
// top-left corner is (bx, by). Right/bottom edges are exclusive.
module shot_hit_test
   import shot_pkg::*;
#(
   parameter int DUCK_W = DEF_DUCK_W,
   parameter int DUCK_H = DEF_DUCK_H
) (
   input  logic [9:0] px,
   input  logic [9:0] py,
   input  logic [9:0] bx,
   input  logic [9:0] by,
   input  logic       active,
   output logic       hit
);

   // One extra bit so a box straddling 1023 does not wrap back to zero.
   logic [10:0] bx_end;
   logic [10:0] by_end;

   assign bx_end = {1'b0, bx} + 11'(DUCK_W);
   assign by_end = {1'b0, by} + 11'(DUCK_H);

   assign hit = active
              && (px >= bx) && ({1'b0, px} < bx_end)
              && (py >= by) && ({1'b0, py} < by_end);

endmodule

// File: rtl/shot_controller.sv
// Turns a left-button press into one registered shot event (position, hit,
// ammo) handed to game logic over valid/ack, then runs flash and cooldown.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | waiting for a press; fires if ammo left, else dry_fire
//   ST_EVAL     | one cycle: hit-test the latched position against the duck
//   ST_REPORT   | shot_valid high until game logic acks
//   ST_COOLDOWN | count frame ticks; flash first, then re-arm
module shot_controller
   import shot_pkg::*;
#(
   parameter int AMMO_MAX        = DEF_AMMO_MAX,
   parameter int DUCK_W          = DEF_DUCK_W,
   parameter int DUCK_H          = DEF_DUCK_H,
   parameter int FLASH_FRAMES    = DEF_FLASH_FRAMES,
   parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       leftButton,
   input  logic [9:0] cursorX,
   input  logic [9:0] cursorY,
   input  logic       frame_tick,
   input  logic       round_start,
   input  logic       duck_active,
   input  logic [9:0] duckX,
   input  logic [9:0] duckY,
   input  logic       shot_ack,
   output logic       shot_valid,
   output logic [9:0] shot_x,
   output logic [9:0] shot_y,
   output logic       shot_hit,
   output logic [3:0] ammo,
   output logic       dry_fire,
   output logic       flash
);

   localparam int              CNT_W       = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CNT_W-1:0] FLASH_CNT  = CNT_W'(FLASH_FRAMES);
   localparam logic [CNT_W-1:0] COOL_CNT   = CNT_W'(COOLDOWN_FRAMES);
   localparam logic [3:0]       AMMO_RELOAD = 4'(AMMO_MAX);

   state_t           state_q, state_d;
   logic             btn_q;
   logic             shot_valid_q, shot_valid_d;
   logic [9:0]       shot_x_q, shot_x_d;
   logic [9:0]       shot_y_q, shot_y_d;
   logic             shot_hit_q, shot_hit_d;
   logic [3:0]       ammo_q, ammo_d;
   logic             dry_fire_q, dry_fire_d;
   logic             flash_q, flash_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             press;
   logic             ack_take;
   logic [CNT_W-1:0] cnt_inc;
   logic             cooldown_done;
   logic             hit_now;

   assign press         = leftButton & ~btn_q;
   // Only an ack seen while the event is actually presented counts.
   assign ack_take      = (state_q == ST_REPORT) && shot_valid_q && shot_ack;
   assign cnt_inc       = cnt_q + CNT_W'(1);
   assign cooldown_done = frame_tick && (cnt_inc == COOL_CNT);

   shot_hit_test #(
      .DUCK_W (DUCK_W),
      .DUCK_H (DUCK_H)
   ) u_hit_test (
      .px     (shot_x_q),
      .py     (shot_y_q),
      .bx     (duckX),
      .by     (duckY),
      .active (duck_active),
      .hit    (hit_now)
   );

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (round_start) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:     if (press && (ammo_q != 4'd0)) state_d = ST_EVAL;
            ST_EVAL:     state_d = ST_REPORT;
            ST_REPORT:   if (ack_take) state_d = ST_COOLDOWN;
            ST_COOLDOWN: if (cooldown_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      shot_valid_d = 1'b0;
      shot_x_d     = shot_x_q;
      shot_y_d     = shot_y_q;
      shot_hit_d   = shot_hit_q;
      ammo_d       = ammo_q;
      dry_fire_d   = 1'b0;
      flash_d      = flash_q;
      cnt_d        = cnt_q;
      if (round_start) begin
         ammo_d  = AMMO_RELOAD;
         flash_d = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               flash_d = 1'b0;
               if (press) begin
                  if (ammo_q != 4'd0) begin
                     shot_x_d = cursorX;
                     shot_y_d = cursorY;
                     ammo_d   = ammo_q - 4'd1;
                  end else begin
                     dry_fire_d = 1'b1;
                  end
               end
            end
            ST_EVAL: begin
               shot_hit_d = hit_now;
            end
            ST_REPORT: begin
               if (ack_take) begin
                  flash_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  shot_valid_d = 1'b1;
               end
            end
            ST_COOLDOWN: begin
               if (frame_tick) begin
                  cnt_d = cnt_inc;
                  if ((cnt_inc >= FLASH_CNT) || cooldown_done) flash_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         btn_q        <= 1'b0;
         shot_valid_q <= 1'b0;
         shot_x_q     <= '0;
         shot_y_q     <= '0;
         shot_hit_q   <= 1'b0;
         ammo_q       <= AMMO_RELOAD;
         dry_fire_q   <= 1'b0;
         flash_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         btn_q        <= leftButton;
         shot_valid_q <= shot_valid_d;
         shot_x_q     <= shot_x_d;
         shot_y_q     <= shot_y_d;
         shot_hit_q   <= shot_hit_d;
         ammo_q       <= ammo_d;
         dry_fire_q   <= dry_fire_d;
         flash_q      <= flash_d;
         cnt_q        <= cnt_d;
      end
   end

   assign shot_valid = shot_valid_q;
   assign shot_x     = shot_x_q;
   assign shot_y     = shot_y_q;
   assign shot_hit   = shot_hit_q;
   assign ammo       = ammo_q;
   assign dry_fire   = dry_fire_q;
   assign flash      = flash_q;

endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Downstream consumer of the mouse interface stage's leftButton, cursorX and cursorY outputs.
- Converts a left-button press into one registered "shot" event for the game logic:
  - latches the cursor position,
  - hit-tests it against the current duck bounding box,
  - spends ammo,
  - drives a frame-timed muzzle flash and cooldown.
- Shots are delivered over a valid/ack handshake so game logic can consume them at its own pace.

Parameters:
- AMMO_MAX, 3, shots per round; also the reset/reload value; range 1..15.
- DUCK_W, 32, duck hitbox width in pixels.
- DUCK_H, 32, duck hitbox height in pixels.
- FLASH_FRAMES, 2, frame ticks flash stays high after ack; must be ≤ COOLDOWN_FRAMES.
- COOLDOWN_FRAMES, 15, frame ticks after ack before a new shot is accepted; must be ≥ 1.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- leftButton  in  1  level from the mouse interface stage, CLOCK_50 domain.
- cursorX  in  10  cursor X, 0..639.
- cursorY  in  10  cursor Y, 0..479.
- frame_tick  in  1  one-cycle pulse per video frame.
- round_start  in  1  one-cycle pulse: reload ammo and abort any pending shot.
- duck_active  in  1  duck is alive and hittable.
- duckX  in  10  duck hitbox top-left X.
- duckY  in  10  duck hitbox top-left Y.
- shot_ack  in  1  game logic has consumed the shot.
- shot_valid  out  1  shot event pending.
- shot_x  out  10  latched shot X.
- shot_y  out  10  latched shot Y.
- shot_hit  out  1  shot landed inside the duck box.
- ammo  out  4  remaining shots.
- dry_fire  out  1  one-cycle pulse: press with ammo == 0.
- flash  out  1  screen-flash enable.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; ammo = AMMO_MAX; shot_valid, shot_hit, dry_fire, flash = 0; shot_x, shot_y = 0; btn_q = 0; frame counter = 0.
- Press detection: press = leftButton & ~btn_q, where btn_q is registered every cycle in every state.
  - A button held through REPORT/COOLDOWN never produces a second shot; it must be released and pressed again.
- FSM states: IDLE, EVAL, REPORT, COOLDOWN.
- IDLE:
  - press with ammo > 0: capture cursorX/cursorY into shot_x/shot_y, ammo -= 1, go to EVAL.
  - press with ammo == 0: dry_fire = 1 for exactly one cycle; stay in IDLE.
- EVAL (1 cycle):
  - shot_hit <= duck_active && shot_x ≥ duckX && shot_x < duckX+DUCK_W && shot_y ≥ duckY && shot_y < duckY+DUCK_H.
  - Sums are computed 11-bit wide, so a box straddling 1023 does not wrap.
  - Go to REPORT.
- REPORT:
  - shot_valid = 1; shot_x, shot_y, shot_hit stable.
  - On shot_ack sampled high: go to COOLDOWN, flash = 1, frame counter = 0. shot_valid is low the following cycle.
  - shot_ack outside REPORT is ignored.
- COOLDOWN:
  - Frame counter increments on each frame_tick.
  - flash drops on the cycle after the counter reaches FLASH_FRAMES.
  - When the counter reaches COOLDOWN_FRAMES: go to IDLE, flash = 0.
- Latency: leftButton first sampled high at edge N → shot_valid high from edge N+2.
- Outputs are registered; shot_hit and shot_x/shot_y hold their last values until the next capture.
- round_start (highest priority, any state):
  - ammo = AMMO_MAX; state IDLE; shot_valid = 0; flash = 0; frame counter cleared.
  - A press in the same cycle is discarded: no capture, no dry_fire.
- Simultaneous press and frame_tick in IDLE: the press is handled normally; the tick is irrelevant.
- duckX/duckY/duck_active are sampled in EVAL only; later changes do not alter shot_hit.

Decomposition:
- Package shot_pkg:
  - state enum typedef (IDLE, EVAL, REPORT, COOLDOWN),
  - SCREEN_W = 640, SCREEN_H = 480,
  - default hitbox and ammo constants.
- Sub-module shot_hit_test:
  - combinational point-in-rectangle test,
  - parameters DUCK_W, DUCK_H; inputs px, py, bx, by, active; output hit.
  - Reused later by the score and hit-animation logic.

Test Plan:
- Reset, then duck at (100,100) active; cursor (110,120); pulse leftButton.
  - shot_valid rises 2 cycles after press; shot_x = 110, shot_y = 120, shot_hit = 1, ammo = 2.
- Duck at (100,100); cursor (132,100) (the right edge, exclusive); press.
  - shot_hit = 0. Repeat with cursor (131,131): shot_hit = 1.
- Hold leftButton high continuously through ack and 20 frame_ticks.
  - Exactly one shot; after release and re-press, a second shot with ammo = 1.
- Fire 3 shots with acks and full cooldowns; press a 4th time.
  - dry_fire pulses one cycle, shot_valid stays 0, ammo = 0.
  - Then pulse round_start: ammo = 3.
- Ack a shot, then issue frame_ticks.
  - flash high until after the 2nd tick; next press ignored until the 15th tick; a press after that is accepted.
- Hold shot_valid pending without ack, then pulse round_start together with a new press.
  - shot_valid = 0 next cycle; state IDLE; ammo = 3; no capture.
  - Assert reset_n low mid-COOLDOWN: flash = 0 immediately, ammo = 3.
